// File: rtl/wishbone_ibus_dbus_arbiter.sv
// Merges the instruction and data Wishbone master ports of a minimal core
// into one Wishbone master port.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | no owner; arbitrate between pending ibus/dbus requests
// ST_OWN_I | ibus owns the bus until ibus_cyc_i falls
// ST_OWN_D | dbus owns the bus until dbus_cyc_i falls
// ST_ABORT | owner timed out; bus released, wait for its cyc to drop
//
// The grant is registered, so a new request reaches the bus one cycle after
// it is first presented. While owned, the owner's signals pass straight
// through to the bus and bus ack/err/dat_r pass straight back.
// last_winner_q doubles as the identity of the aborted master in ST_ABORT.
module wishbone_ibus_dbus_arbiter #(
   parameter int TIMEOUT_CYCLES = 256,
   parameter int FIRST_PRIORITY = 0,
   parameter int ADDR_W         = 30,
   parameter int DATA_W         = 32,
   parameter int SEL_W          = DATA_W / 8
) (
   input  logic              clk,
   input  logic              rst,

   input  logic [ADDR_W-1:0] ibus_adr_i,
   input  logic [DATA_W-1:0] ibus_dat_w_i,
   input  logic [SEL_W-1:0]  ibus_sel_i,
   input  logic              ibus_cyc_i,
   input  logic              ibus_stb_i,
   input  logic              ibus_we_i,
   input  logic [2:0]        ibus_cti_i,
   input  logic [1:0]        ibus_bte_i,
   output logic [DATA_W-1:0] ibus_dat_r_o,
   output logic              ibus_ack_o,
   output logic              ibus_err_o,

   input  logic [ADDR_W-1:0] dbus_adr_i,
   input  logic [DATA_W-1:0] dbus_dat_w_i,
   input  logic [SEL_W-1:0]  dbus_sel_i,
   input  logic              dbus_cyc_i,
   input  logic              dbus_stb_i,
   input  logic              dbus_we_i,
   input  logic [2:0]        dbus_cti_i,
   input  logic [1:0]        dbus_bte_i,
   output logic [DATA_W-1:0] dbus_dat_r_o,
   output logic              dbus_ack_o,
   output logic              dbus_err_o,

   output logic [ADDR_W-1:0] bus_adr_o,
   output logic [DATA_W-1:0] bus_dat_w_o,
   output logic [SEL_W-1:0]  bus_sel_o,
   output logic              bus_cyc_o,
   output logic              bus_stb_o,
   output logic              bus_we_o,
   output logic [2:0]        bus_cti_o,
   output logic [1:0]        bus_bte_o,
   input  logic [DATA_W-1:0] bus_dat_r_i,
   input  logic              bus_ack_i,
   input  logic              bus_err_i,

   output logic [1:0]        grant_o,
   output logic              timeout_o
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_OWN_I = 2'd1,
      ST_OWN_D = 2'd2,
      ST_ABORT = 2'd3
   } state_e;

   // last winner encoding: 0 = ibus, 1 = dbus; the tie goes to the other one
   localparam logic LAST_INIT = (FIRST_PRIORITY == 0);

   state_e     state_q;
   logic       last_winner_q;
   logic [1:0] grant_q;

   logic req_ibus;
   logic req_dbus;
   logic owning;
   logic own_cyc;
   logic own_stb;
   logic abort_cyc;
   logic fire;

   assign req_ibus  = ibus_cyc_i & ibus_stb_i;
   assign req_dbus  = dbus_cyc_i & dbus_stb_i;
   assign owning    = |grant_q;
   assign own_cyc   = (grant_q[0] & ibus_cyc_i) | (grant_q[1] & dbus_cyc_i);
   assign own_stb   = (grant_q[0] & ibus_stb_i) | (grant_q[1] & dbus_stb_i);
   assign abort_cyc = last_winner_q ? dbus_cyc_i : ibus_cyc_i;

   generate
      if (TIMEOUT_CYCLES > 0) begin : g_timeout
         localparam int              CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
         localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

         logic [CNT_W-1:0] cnt_q;
         logic [CNT_W-1:0] cnt_d;
         logic             waiting;

         // a strobed, unanswered beat of the current owner that keeps its grant
         assign waiting = owning & own_cyc & own_stb & ~bus_ack_i & ~bus_err_i;
         assign fire    = owning & own_stb & ~bus_ack_i & ~bus_err_i & (cnt_q == CNT_LAST);

         // count consecutive waiting cycles; anything else (ack, err, gap, grant change) clears
         always_comb begin
            cnt_d = '0;
            if (waiting && !fire) begin
               cnt_d = cnt_q + 1'b1;
            end
         end

         // wait counter register
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               cnt_q <= '0;
            end else begin
               cnt_q <= cnt_d;
            end
         end
      end else begin : g_no_timeout
         assign fire = 1'b0;
      end
   endgenerate

   // arbitration FSM; grant_q is the registered owner and drives all muxing
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= ST_IDLE;
         last_winner_q <= LAST_INIT;
         grant_q       <= 2'b00;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (req_ibus && (!req_dbus || last_winner_q)) begin
                  state_q       <= ST_OWN_I;
                  last_winner_q <= 1'b0;
                  grant_q       <= 2'b01;
               end else if (req_dbus) begin
                  state_q       <= ST_OWN_D;
                  last_winner_q <= 1'b1;
                  grant_q       <= 2'b10;
               end
            end
            ST_OWN_I: begin
               if (fire) begin
                  state_q <= ST_ABORT;
                  grant_q <= 2'b00;
               end else if (!ibus_cyc_i) begin
                  if (req_dbus) begin
                     state_q       <= ST_OWN_D;
                     last_winner_q <= 1'b1;
                     grant_q       <= 2'b10;
                  end else begin
                     state_q <= ST_IDLE;
                     grant_q <= 2'b00;
                  end
               end
            end
            ST_OWN_D: begin
               if (fire) begin
                  state_q <= ST_ABORT;
                  grant_q <= 2'b00;
               end else if (!dbus_cyc_i) begin
                  if (req_ibus) begin
                     state_q       <= ST_OWN_I;
                     last_winner_q <= 1'b0;
                     grant_q       <= 2'b01;
                  end else begin
                     state_q <= ST_IDLE;
                     grant_q <= 2'b00;
                  end
               end
            end
            ST_ABORT: begin
               if (!abort_cyc) begin
                  state_q <= ST_IDLE;
               end
            end
            default: begin
               state_q <= ST_IDLE;
               grant_q <= 2'b00;
            end
         endcase
      end
   end

   // bus pass-through and response steering; responses outside ownership are dropped
   always_comb begin
      bus_adr_o   = '0;
      bus_dat_w_o = '0;
      bus_sel_o   = '0;
      bus_cyc_o   = 1'b0;
      bus_stb_o   = 1'b0;
      bus_we_o    = 1'b0;
      bus_cti_o   = '0;
      bus_bte_o   = '0;
      ibus_ack_o  = 1'b0;
      ibus_err_o  = 1'b0;
      dbus_ack_o  = 1'b0;
      dbus_err_o  = 1'b0;
      if (grant_q[0]) begin
         bus_adr_o   = ibus_adr_i;
         bus_dat_w_o = ibus_dat_w_i;
         bus_sel_o   = ibus_sel_i;
         bus_cyc_o   = ibus_cyc_i & ~fire;
         bus_stb_o   = ibus_stb_i & ~fire;
         bus_we_o    = ibus_we_i;
         bus_cti_o   = ibus_cti_i;
         bus_bte_o   = ibus_bte_i;
         ibus_ack_o  = bus_ack_i;
         ibus_err_o  = bus_err_i | fire;
      end else if (grant_q[1]) begin
         bus_adr_o   = dbus_adr_i;
         bus_dat_w_o = dbus_dat_w_i;
         bus_sel_o   = dbus_sel_i;
         bus_cyc_o   = dbus_cyc_i & ~fire;
         bus_stb_o   = dbus_stb_i & ~fire;
         bus_we_o    = dbus_we_i;
         bus_cti_o   = dbus_cti_i;
         bus_bte_o   = dbus_bte_i;
         dbus_ack_o  = bus_ack_i;
         dbus_err_o  = bus_err_i | fire;
      end
   end

   assign ibus_dat_r_o = bus_dat_r_i;
   assign dbus_dat_r_o = bus_dat_r_i;
   assign grant_o      = grant_q;
   assign timeout_o    = fire;

endmodule
